// File: rtl/stroke_err_accum.sv
// Streaming stroke error evaluator: per-pixel SAD of ref vs canvas and ref vs stroke colour,
// two-stage pipeline, saturating totals and an accept flag for the canvas writer.
//
// state | meaning
// IDLE  | waiting for start; totals and accept hold from the previous stroke
// RUN   | taking pixel beats until N have transferred
// DRAIN | letting the last beat leave the pipeline
// DONE  | one-cycle done pulse; accept already registered
module stroke_err_accum #(
  parameter int PIX_W = 8,
  parameter int CH    = 3,
  parameter int LEN_W = 8,
  parameter int ACC_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH*PIX_W-1:0]   stroke_color,
  input  logic [LEN_W-1:0]      stroke_len,
  output logic                  busy,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [CH*PIX_W-1:0]   ref_pix,
  input  logic [CH*PIX_W-1:0]   canvas_pix,
  output logic                  mask_valid,
  output logic                  mask,
  output logic                  done,
  output logic [ACC_W-1:0]      err_old,
  output logic [ACC_W-1:0]      err_new,
  output logic                  accept
);

  localparam int SUM_W = PIX_W + 2;
  localparam int SW    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CH*PIX_W-1:0] color_q, color_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W:0]      cnt_inc;
  logic                last_beat;
  logic                xfer;
  logic                start_acc;

  logic [PIX_W:0]   diff_old [CH];
  logic [PIX_W:0]   diff_new [CH];
  logic [PIX_W-1:0] abs_old  [CH];
  logic [PIX_W-1:0] abs_new  [CH];
  logic [PIX_W-1:0] s1_old_q [CH];
  logic [PIX_W-1:0] s1_new_q [CH];
  logic             s1_v_q, s1_v_d;

  logic [SUM_W-1:0] sum_old, sum_new;
  logic [SW-1:0]    tot_old, tot_new;
  logic             mask_v_q, mask_v_d;
  logic             mask_q, mask_d;
  logic [ACC_W-1:0] err_old_q, err_old_d;
  logic [ACC_W-1:0] err_new_q, err_new_d;
  logic             accept_q, accept_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (stroke_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (xfer && last_beat) state_d = S_DRAIN;
      S_DRAIN: if (!s1_v_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = 1'b0;
    pix_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_RUN:   begin busy = 1'b1; pix_ready = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  assign xfer      = pix_valid & pix_ready;
  assign start_acc = (state_q == S_IDLE) & start;
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign last_beat = (cnt_inc == {1'b0, len_q});

  // Stage 1: per-channel magnitudes from a one-bit-wider signed difference
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      diff_old[i] = {1'b0, ref_pix[i*PIX_W +: PIX_W]} - {1'b0, canvas_pix[i*PIX_W +: PIX_W]};
      diff_new[i] = {1'b0, ref_pix[i*PIX_W +: PIX_W]} - {1'b0, color_q[i*PIX_W +: PIX_W]};
      abs_old[i]  = diff_old[i][PIX_W] ? (~diff_old[i][PIX_W-1:0] + 1'b1) : diff_old[i][PIX_W-1:0];
      abs_new[i]  = diff_new[i][PIX_W] ? (~diff_new[i][PIX_W-1:0] + 1'b1) : diff_new[i][PIX_W-1:0];
    end
  end

  // Stage 2: channel sums, compare, saturating accumulate
  always_comb begin
    sum_old = '0;
    sum_new = '0;
    for (int i = 0; i < CH; i++) begin
      sum_old = sum_old + {2'b00, s1_old_q[i]};
      sum_new = sum_new + {2'b00, s1_new_q[i]};
    end
    tot_old = SW'(err_old_q) + SW'(sum_old);
    tot_new = SW'(err_new_q) + SW'(sum_new);
  end

  always_comb begin
    color_d   = start_acc ? stroke_color : color_q;
    len_d     = start_acc ? stroke_len : len_q;
    cnt_d     = cnt_q;
    if (start_acc)  cnt_d = '0;
    else if (xfer)  cnt_d = cnt_inc[LEN_W-1:0];
    s1_v_d    = xfer;
    mask_v_d  = s1_v_q;
    mask_d    = s1_v_q & (sum_new < sum_old);
    err_old_d = err_old_q;
    err_new_d = err_new_q;
    accept_d  = accept_q;
    if (start_acc) begin
      err_old_d = '0;
      err_new_d = '0;
      accept_d  = 1'b0;
    end else begin
      if (s1_v_q) begin
        err_old_d = (tot_old > ACC_MAX) ? {ACC_W{1'b1}} : tot_old[ACC_W-1:0];
        err_new_d = (tot_new > ACC_MAX) ? {ACC_W{1'b1}} : tot_new[ACC_W-1:0];
      end
      // Totals are final here, so accept is ready in the same cycle as done
      if (state_q == S_DRAIN && !s1_v_q) accept_d = (err_new_q < err_old_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      s1_v_q    <= 1'b0;
      mask_v_q  <= 1'b0;
      mask_q    <= 1'b0;
      err_old_q <= '0;
      err_new_q <= '0;
      accept_q  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        s1_old_q[i] <= '0;
        s1_new_q[i] <= '0;
      end
    end else begin
      color_q   <= color_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      s1_v_q    <= s1_v_d;
      mask_v_q  <= mask_v_d;
      mask_q    <= mask_d;
      err_old_q <= err_old_d;
      err_new_q <= err_new_d;
      accept_q  <= accept_d;
      if (xfer) begin
        for (int i = 0; i < CH; i++) begin
          s1_old_q[i] <= abs_old[i];
          s1_new_q[i] <= abs_new[i];
        end
      end
    end
  end

  assign mask_valid = mask_v_q;
  assign mask       = mask_q;
  assign err_old    = err_old_q;
  assign err_new    = err_new_q;
  assign accept     = accept_q;

endmodule

// File: tb/tb_stroke_err_accum.sv
// Scoreboard bench for stroke_err_accum (ACC_W=10 so saturation is reachable with short strokes).
module tb_stroke_err_accum;
  localparam int PW = 8, CH = 3, LW = 8, AW = 10, MAXACC = 1023;

  logic           clk = 1'b0, rst = 1'b0;
  logic           start = 1'b0, pix_valid = 1'b0;
  logic [23:0]    stroke_color = '0, ref_pix = '0, canvas_pix = '0;
  logic [7:0]     stroke_len = '0;
  logic           busy, pix_ready, mask_valid, mask, done, accept;
  logic [AW-1:0]  err_old, err_new;

  stroke_err_accum #(.PIX_W(PW), .CH(CH), .LEN_W(LW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stroke_color(stroke_color),
    .stroke_len(stroke_len), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ref_pix(ref_pix), .canvas_pix(canvas_pix), .mask_valid(mask_valid), .mask(mask),
    .done(done), .err_old(err_old), .err_new(err_new), .accept(accept));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit m; int c; } mexp_t;
  typedef struct { int o; int n; bit a; int c; } sexp_t;
  mexp_t mq[$];
  sexp_t sq[$];
  logic [23:0] refq[$], canq[$];
  bit vq[$];
  mexp_t me;
  sexp_t se;
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sad(input logic [23:0] a, input logic [23:0] b);
    int s = 0;
    for (int i = 0; i < CH; i++) begin
      int x = int'(a[i*8 +: 8]) - int'(b[i*8 +: 8]);
      s += (x < 0) ? -x : x;
    end
    return s;
  endfunction

  function automatic logic [23:0] rand_pix(input bit narrow);
    logic [23:0] p;
    for (int i = 0; i < CH; i++)
      p[i*8 +: 8] = narrow ? 8'($urandom_range(100, 131)) : 8'($urandom);
    return p;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst) begin
      if (mask_valid) begin
        if (mq.size() == 0) begin
          tests++; fails++;
          $display("FAIL mask_unexpected: got mask_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          me = mq.pop_front();
          check("mask", mask, me.m);
          check("mask_cycle", cyc, me.c);
        end
      end
      if (done) begin
        if (sq.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          se = sq.pop_front();
          check("done_err_old", err_old, se.o);
          check("done_err_new", err_new, se.n);
          check("done_accept", accept, se.a);
          check("done_cycle", cyc, se.c);
        end
      end
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_pix_ready"}, pix_ready, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_mask_valid"}, mask_valid, 0);
    check({pfx, "_mask"}, mask, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_accept"}, accept, 0);
    check({pfx, "_err_old"}, err_old, 0);
    check({pfx, "_err_new"}, err_new, 0);
  endtask

  // Called at #1 after a posedge in an IDLE cycle; returns in the first IDLE cycle after the stroke
  task automatic do_stroke(input int n, input logic [23:0] col, input bit bub,
                           input bit narrow, input bit poke);
    int t, sent, guard, hl, o, nw, so, sn;
    logic [23:0] r, c;
    bit v;
    o = 0; nw = 0; t = cyc; hl = t - 2;
    start = 1'b1; stroke_len = n[7:0]; stroke_color = col;
    if (n == 0) sq.push_back('{0, 0, 1'b0, t + 1});
    @(posedge clk); #1;
    start = 1'b0; stroke_color = 24'($urandom); stroke_len = 8'($urandom);
    check("busy_rise", busy, 1);
    check("ready_rise", pix_ready, (n > 0));
    sent = 0; guard = 0;
    while (sent < n && guard < 300) begin
      v = (vq.size() > 0) ? vq.pop_front() : (bub ? bit'($urandom_range(0, 1)) : 1'b1);
      r = (refq.size() > 0) ? refq.pop_front() : rand_pix(narrow);
      c = (canq.size() > 0) ? canq.pop_front() : rand_pix(narrow);
      pix_valid = v; ref_pix = r; canvas_pix = c;
      start = poke && (sent == 1);
      if (v && pix_ready) begin
        so = sad(r, c);
        sn = sad(r, col);
        mq.push_back('{(sn < so), cyc + 2});
        o  = (o + so > MAXACC) ? MAXACC : o + so;
        nw = (nw + sn > MAXACC) ? MAXACC : nw + sn;
        sent++;
        hl = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (sent < n) begin
      tests++; fails++;
      $display("FAIL beat_timeout: got %0d transfers, expected %0d", sent, n);
    end
    if (n > 0) begin
      check("ready_drop", pix_ready, 0);
      sq.push_back('{o, nw, (nw < o), hl + 3});
    end
    guard = 0;
    while (busy && guard < 50) begin
      pix_valid = bit'($urandom_range(0, 1));
      ref_pix = 24'($urandom); canvas_pix = 24'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    pix_valid = 1'b0;
    check("busy_fall_cycle", cyc, hl + 4);
    check("hold_err_old", err_old, o);
    check("hold_err_new", err_new, nw);
    check("hold_accept", accept, (nw < o));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rp, wc;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Single pixel
    refq.push_back({8'd100, 8'd90, 8'd110});
    canq.push_back(24'd0);
    do_stroke(1, {3{8'd100}}, 0, 0, 0);
    check("single_err_old", err_old, 300);
    check("single_err_new", err_new, 20);
    check("single_accept", accept, 1);

    // Tie
    repeat (2) begin refq.push_back({3{8'd7}}); canq.push_back({3{8'd7}}); end
    do_stroke(2, {3{8'd7}}, 0, 0, 0);
    check("tie_err_old", err_old, 0);
    check("tie_err_new", err_new, 0);
    check("tie_accept", accept, 0);

    // Bubbles: valid 1,0,1,1,0,1; canvas worse on transfers 0 and 2
    rp = {8'd70, 8'd60, 8'd50};
    wc = 24'd0;
    foreach (vq[i]) ;
    vq.push_back(1); vq.push_back(0); vq.push_back(1);
    vq.push_back(1); vq.push_back(0); vq.push_back(1);
    repeat (6) refq.push_back(rp);
    canq.push_back(wc); canq.push_back(wc); canq.push_back(rp);
    canq.push_back(wc); canq.push_back(wc); canq.push_back(rp);
    do_stroke(4, rp, 0, 0, 0);
    check("bubble_err_old", err_old, 360);
    check("bubble_err_new", err_new, 0);

    // Zero-length stroke
    do_stroke(0, rand_pix(0), 0, 0, 0);
    check("n0_err_old", err_old, 0);
    check("n0_err_new", err_new, 0);
    check("n0_accept", accept, 0);

    // Saturation
    repeat (3) begin refq.push_back({3{8'd255}}); canq.push_back(24'd0); end
    do_stroke(3, {3{8'd255}}, 0, 0, 0);
    check("sat_err_old", err_old, 1023);
    check("sat_err_new", err_new, 0);
    check("sat_accept", accept, 1);

    // Start pulsed while busy
    do_stroke(5, rand_pix(1), 0, 1, 1);

    // Reset during the third beat of a stroke
    start = 1'b1; stroke_len = 8'd5; stroke_color = rand_pix(1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      pix_valid = 1'b1; ref_pix = rand_pix(1); canvas_pix = rand_pix(1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_stroke(3, rand_pix(1), 0, 1, 0);

    // Randomized strokes, back to back
    for (int k = 0; k < 30; k++) begin
      bit nar;
      nar = bit'($urandom_range(0, 1));
      do_stroke($urandom_range(0, 8), rand_pix(nar), bit'($urandom_range(0, 1)), nar,
                bit'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("mask_queue_empty", mq.size(), 0);
    check("done_queue_empty", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
